// File: rtl/i2c_line_driver.sv
// Open-drain SCL/SDA pad sequencer with hold/setup spacing, clock-stretch wait
// and arbitration-loss detection. Define I2C_STRETCH_TIMEOUT_EN for the stretch timeout.
module i2c_line_driver #(
  parameter int HOLD_CYCLES    = 4,
  parameter int SETUP_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic cmd_scl,
  input  logic cmd_sda,
  input  logic scl_in,
  input  logic sda_in,
  input  logic err_clr,
  output logic scl_oe,
  output logic sda_oe,
  output logic arb_lost,
  output logic timeout
);

`ifdef I2C_STRETCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, SETUP, WAIT_HIGH} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             scl_oe_q, scl_oe_d;
  logic             sda_oe_q, sda_oe_d;
  logic             sda_lat_q, sda_lat_d;
  logic             armed_q, armed_d;
  logic             arb_q, arb_d;
  logic             to_q, to_d;
  logic             arb_set, to_set;

  assign cmd_ready = (state_q == IDLE);
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;
  assign arb_lost  = arb_q;
  assign timeout   = TO_EN ? to_q : 1'b0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    scl_oe_d  = scl_oe_q;
    sda_oe_d  = sda_oe_q;
    sda_lat_d = sda_lat_q;
    armed_d   = armed_q;
    to_set    = 1'b0;
    // We released SDA but the bus reads low while SCL is high: someone else owns it.
    arb_set   = (state_q == IDLE) && armed_q && !scl_oe_q && scl_in && !sda_oe_q && !sda_in;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          armed_d = 1'b1;
          cnt_d   = '0;
          if (!arb_q) begin
            if (!cmd_scl) begin
              scl_oe_d  = 1'b1;
              sda_lat_d = cmd_sda;
              state_d   = HOLD;
            end else begin
              sda_oe_d  = ~cmd_sda;
              state_d   = SETUP;
            end
          end
        end
      end
      HOLD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == HOLD_LAST) begin
          sda_oe_d = ~sda_lat_q;
          state_d  = IDLE;
          cnt_d    = '0;
        end
      end
      SETUP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == SETUP_LAST) begin
          scl_oe_d = 1'b0;
          state_d  = WAIT_HIGH;
          cnt_d    = '0;
        end
      end
      WAIT_HIGH: begin
        if (scl_in) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (TO_EN && (cnt_q == TO_LAST)) begin
            to_set   = 1'b1;
            scl_oe_d = 1'b0;
            sda_oe_d = 1'b0;
            state_d  = IDLE;
            cnt_d    = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // After losing arbitration both lines stay released and commands just drain.
    if (arb_q) begin
      scl_oe_d = 1'b0;
      sda_oe_d = 1'b0;
      state_d  = IDLE;
      cnt_d    = '0;
    end

    arb_d = arb_set | (arb_q & ~err_clr);
    to_d  = to_set  | (to_q  & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
      sda_lat_q <= 1'b1;
      armed_q   <= 1'b0;
      arb_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
      sda_lat_q <= sda_lat_d;
      armed_q   <= armed_d;
      arb_q     <= arb_d;
      to_q      <= to_d;
    end
  end

endmodule

// File: tb/tb_i2c_line_driver.sv
// Directed-vector bench for i2c_line_driver; SCL readback is the released line
// delayed six cycles unless a stretch is being forced.
module tb_i2c_line_driver;

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic reset_n, cmd_valid, cmd_ready, cmd_scl, cmd_sda;
  logic scl_in, sda_in, err_clr, scl_oe, sda_oe, arb_lost, timeout;
  logic sl, st;
  logic [5:0] dly = '1;

  always @(posedge gclk) dly <= {dly[4:0], ~scl_oe};
  assign scl_in = st ? 1'b0 : dly[5];
  assign sda_in = ~sl;

  i2c_line_driver dut (
    .clk(gclk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_scl(cmd_scl), .cmd_sda(cmd_sda), .scl_in(scl_in), .sda_in(sda_in),
    .err_clr(err_clr), .scl_oe(scl_oe), .sda_oe(sda_oe), .arb_lost(arb_lost),
    .timeout(timeout)
  );

  // exp = {scl_oe, sda_oe, cmd_ready, arb_lost, timeout} after the edge
  typedef struct packed {
    logic v, s, d, sl, st, ec;
    logic [4:0] exp;
  } vec_t;

  vec_t vq[$];
  int nvec = 0;
  int nerr = 0;

  task automatic add(input logic v, s, d, l, t, ec, input logic [4:0] e, input int n);
    vec_t r;
    r.v = v; r.s = s; r.d = d; r.sl = l; r.st = t; r.ec = ec; r.exp = e;
    for (int k = 0; k < n; k++) vq.push_back(r);
  endtask

  task automatic check(input string name, input logic [4:0] e);
    logic [4:0] got;
    got = {scl_oe, sda_oe, cmd_ready, arb_lost, timeout};
    nvec++;
    if (got !== e) begin
      nerr++;
      $display("FAIL %s: got {scl_oe,sda_oe,rdy,arb,to}=%b want %b", name, got, e);
    end
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_scl = 1'b1; cmd_sda = 1'b1;
    err_clr = 1'b0; sl = 1'b0; st = 1'b0;

    // idle with SDA low: no arbitration before the first command
    add(0,0,0,1,0,0, 5'b00100, 20);
    // (0,0): SCL low now, SDA low after HOLD
    add(1,0,0,0,0,0, 5'b10000, 1);
    add(0,0,0,0,0,0, 5'b10000, 3);
    add(0,0,0,0,0,0, 5'b11100, 1);
    // (1,1): SDA release at accept, SCL release 8 later, IDLE once readback high
    add(1,1,1,0,0,0, 5'b10000, 1);
    add(0,0,0,0,0,0, 5'b10000, 7);
    add(0,0,0,0,0,0, 5'b00000, 7);
    add(0,0,0,0,0,0, 5'b00100, 1);
    // arbitration loss, command drained, set beats clear, then clear
    add(0,0,0,1,0,0, 5'b00110, 1);
    add(1,0,0,0,0,0, 5'b00110, 1);
    add(0,0,0,0,0,0, 5'b00110, 1);
    add(0,0,0,1,0,1, 5'b00110, 1);
    add(0,0,0,0,0,1, 5'b00100, 1);
    // stretch: SCL readback held low
    add(1,1,1,0,1,0, 5'b00000, 1);
    add(0,0,0,0,1,0, 5'b00000, 8);
`ifdef I2C_STRETCH_TIMEOUT_EN
    add(0,0,0,0,1,0, 5'b00000, 254);
    add(0,0,0,0,1,0, 5'b00101, 1);
    add(0,0,0,0,1,0, 5'b00101, 40);
`else
    add(0,0,0,0,1,0, 5'b00000, 300);
`endif
    add(0,0,0,0,0,1, 5'b00100, 1);
    // (0,0) then (0,1): SDA released while SCL held low
    add(1,0,0,0,0,0, 5'b10000, 1);
    add(0,0,0,0,0,0, 5'b10000, 3);
    add(0,0,0,0,0,0, 5'b11100, 1);
    add(1,0,1,0,0,0, 5'b11000, 1);
    add(0,0,0,0,0,0, 5'b11000, 3);
    add(0,0,0,0,0,0, 5'b10100, 1);

    repeat (3) @(negedge gclk);
    check("reset", 5'b00100);
    reset_n = 1'b1;

    foreach (vq[i]) begin
      cmd_valid = vq[i].v; cmd_scl = vq[i].s; cmd_sda = vq[i].d;
      sl = vq[i].sl; st = vq[i].st; err_clr = vq[i].ec;
      @(negedge gclk);
      check($sformatf("vec%0d", i), vq[i].exp);
    end

    // reset in the middle of SETUP abandons the command
    cmd_valid = 1'b1; cmd_scl = 1'b1; cmd_sda = 1'b0;
    @(negedge gclk);
    check("setup_accept", 5'b11000);
    cmd_valid = 1'b0;
    repeat (2) @(negedge gclk);
    check("setup_mid", 5'b11000);
    reset_n = 1'b0;
    @(negedge gclk);
    check("setup_reset", 5'b00100);
    reset_n = 1'b1;
    sl = 1'b1;
    @(negedge gclk);
    check("post_reset_unarmed", 5'b00100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/i2c_line_driver.md
# i2c_line_driver

Open-drain output driver for the SCL/SDA pads of the I2C controller; it is the transmit counterpart of the input synchroniser/glitch filter. It accepts bit-phase commands, each a target SCL/SDA level pair, and sequences the pad output enables with programmable SDA hold and setup spacing. It waits out clock stretching by watching filtered SCL readback, and detects arbitration loss by comparing released SDA against filtered SDA readback.

## Interface
- HOLD_CYCLES, 4: clk cycles from SCL driven low to SDA update (≥1).
- SETUP_CYCLES, 8: clk cycles from SDA update to SCL release (≥1). Must exceed the readback path latency: 2 sync + 3 filter + 1 output stage.
- TIMEOUT_CYCLES, 255: stretch timeout, in clk cycles of SCL held low while released.
- CNT_W, 8: counter width. Must hold max(HOLD_CYCLES, SETUP_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  input  1  single clock.
- reset_n  input  1  synchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted on an edge where cmd_valid && cmd_ready.
- cmd_scl  input  1  target SCL (1 = release).
- cmd_sda  input  1  target SDA (1 = release).
- scl_in  input  1  filtered SCL readback.
- sda_in  input  1  filtered SDA readback.
- err_clr  input  1  clears sticky error flags.
- scl_oe  output  1  1 = pull SCL low.
- sda_oe  output  1  1 = pull SDA low.
- arb_lost  output  1  sticky arbitration-loss flag.
- timeout  output  1  sticky stretch-timeout flag.

## Operation
- States: IDLE, HOLD, SETUP, WAIT_HIGH. cmd_ready = (state == IDLE). Counter `cnt` is cleared on every state entry.
- IDLE, accept with cmd_scl = 0:
  - scl_oe <= 1, go HOLD.
  - HOLD increments cnt each edge. At the edge where cnt == HOLD_CYCLES-1: sda_oe <= ~cmd_sda (latched), go IDLE.
- IDLE, accept with cmd_scl = 1:
  - sda_oe <= ~cmd_sda, go SETUP.
  - SETUP increments cnt. At the edge where cnt == SETUP_CYCLES-1: scl_oe <= 0, go WAIT_HIGH.
  - WAIT_HIGH: the first edge with scl_in == 1 goes to IDLE. Otherwise cnt increments (stretching).
  - SDA changes while SCL is high (START/STOP) are legal. The driver does not police them.
- Arbitration:
  - `armed` is set on the first accepted command after reset.
  - In IDLE with armed, scl_oe == 0, scl_in == 1, sda_oe == 0 and sda_in == 0: arb_lost <= 1.
  - No check in HOLD, SETUP or WAIT_HIGH.
- While arb_lost = 1:
  - scl_oe and sda_oe are forced 0 at the next edge and held there.
  - Commands are still accepted and complete in one cycle; state stays IDLE, cmd_ready stays 1.
- err_clr clears arb_lost and timeout. If a set condition occurs on the same edge as err_clr, the set wins.
- Reset (sampled on a clk edge) clears everything: scl_oe = 0, sda_oe = 0, arb_lost = 0, timeout = 0, armed = 0, state IDLE, cmd_ready = 1. Reset mid-command abandons it with both lines released.

## Timing
- Accept edge N, cmd_scl = 0:
  - scl_oe high after edge N.
  - sda_oe updates at edge N+HOLD_CYCLES.
  - cmd_ready high after that edge.
- Accept edge N, cmd_scl = 1:
  - sda_oe updates at edge N.
  - scl_oe falls at edge N+SETUP_CYCLES.
  - IDLE at the first later edge M with scl_in == 1. Minimum M = N+SETUP_CYCLES+1.
- Back-to-back throughput: one command per HOLD_CYCLES+1 cycles (SCL low) or SETUP_CYCLES+2 cycles (SCL high, no stretch).
- A redundant command (target equals current levels) follows the same sequence and timing.
- The arbitration flag is visible one cycle after the qualifying IDLE edge.

## Configuration
- Macro: I2C_STRETCH_TIMEOUT_EN.
- Defined:
  - WAIT_HIGH counts cycles with scl_in == 0.
  - At the edge where cnt == TIMEOUT_CYCLES-1: timeout <= 1, scl_oe <= 0, sda_oe <= 0, go IDLE.
- Undefined:
  - WAIT_HIGH waits indefinitely.
  - timeout is tied 0 and TIMEOUT_CYCLES is ignored.

## Test plan
- Reset, then idle 20 cycles -> scl_oe = sda_oe = 0, cmd_ready = 1, arb_lost = timeout = 0, even with sda_in held 0.
- Command (0,0) accepted at edge N, defaults -> scl_oe = 1 from N+1, sda_oe = 1 from N+4, cmd_ready back high after edge N+4.
- Command (1,1), scl_in tied to ~scl_oe delayed 6 cycles -> sda_oe = 0 at N, scl_oe = 0 at N+8, IDLE at N+15.
- Stretch: scl_in held 0 for 300 cycles after release:
  - with macro: timeout = 1 at cnt 254, both oe = 0;
  - without macro: remains in WAIT_HIGH, cmd_ready = 0.
- After (1,1) completes, force sda_in = 0 -> arb_lost = 1 next cycle. A following (0,0) command is accepted but both oe stay 0. err_clr -> arb_lost = 0.
- Assert reset_n = 0 during SETUP -> next edge both oe = 0, state IDLE, cmd_ready = 1.
